// File: rtl/apb_regfile_slave_pkg.sv
// Shared types and widths for the APB register-file completer.
package apb_pkg;

    localparam int APB_ADDR_W     = 32;
    localparam int APB_DATA_W     = 32;
    localparam int APB_WORD_BYTES = 4;

    // Completer FSM: idle until an access phase, count wait states, respond once.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } apb_slv_state_t;

endpackage

// File: rtl/apb_regfile_slave_reg_bank.sv
// Data registers plus saturating read/write counters. One index serves both
// the write port and the combinational read port; index NUM_REGS selects the
// read-only status word {rd_cnt, wr_cnt}.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 4
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [APB_DATA_W-1:0] wr_data,
    input  logic                  rd_inc,
    input  logic                  wr_inc,
    output logic [APB_DATA_W-1:0] rd_data
);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];
    logic [15:0]           rd_cnt;
    logic [15:0]           wr_cnt;

    // Register array: cleared by reset, written one word per committed write.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (idx == IDX_W'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Success counters stick at all-ones instead of wrapping.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_inc && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (wr_inc && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    // Read mux; indices beyond the status word read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_data = regs[i];
            end
        end
        if (idx == IDX_W'(NUM_REGS)) begin
            rd_data = {rd_cnt, wr_cnt};
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer fronting a small register bank with programmable wait states.
//
// Handshake: an access is accepted only when psel_i and penable_i are both
// high in S_IDLE (setup-phase psel_i alone is ignored). The response is a
// single registered pready_o pulse; prdata_o/pslverr_o are meaningful only
// in that cycle and are zero otherwise. Dropping psel_i while waiting aborts
// the access with no response, no commit and no count.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'hA000,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [APB_ADDR_W-1:0] paddr_i,
    input  logic                  pwrite_i,
    input  logic [APB_DATA_W-1:0] pwdata_i,
    output logic [APB_DATA_W-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o
);

    localparam int          IDX_W   = $clog2(NUM_REGS + 1);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    apb_slv_state_t        state;
    logic [3:0]            wait_cnt;
    logic [APB_ADDR_W-1:0] cap_addr;
    logic                  cap_write;
    logic [APB_DATA_W-1:0] cap_wdata;

    logic                  access;
    logic                  in_idle;
    logic [APB_ADDR_W-1:0] dec_addr;
    logic                  dec_write;
    logic [APB_ADDR_W-1:0] word_off;
    logic                  dec_in_range;
    logic                  dec_is_status;
    logic                  dec_err;
    logic [IDX_W-1:0]      dec_idx;
    logic                  enter_resp;
    logic                  commit_ok;
    logic                  bank_wr_en;
    logic                  bank_rd_inc;
    logic                  bank_wr_inc;
    logic [APB_DATA_W-1:0] bank_rd_data;

    assign access  = psel_i & penable_i;
    assign in_idle = (state == S_IDLE);

    // Decode the live bus in S_IDLE (the zero-wait path enters S_RESP on the
    // capture edge itself) and the captured transfer everywhere else.
    always_comb begin
        dec_addr      = in_idle ? paddr_i : cap_addr;
        dec_write     = in_idle ? pwrite_i : cap_write;
        word_off      = (dec_addr - BASE_ADDR) >> 2;
        dec_in_range  = (dec_addr >= BASE_ADDR) && (word_off <= 32'(NUM_REGS));
        dec_is_status = (word_off == 32'(NUM_REGS));
        dec_idx       = word_off[IDX_W-1:0];
        dec_err       = !dec_in_range
                        || (dec_addr[1:0] != 2'b00)
                        || (dec_write && dec_is_status);
    end

    // Response is due next cycle: straight from idle with no wait states, or
    // on the last wait state while the requester still holds psel_i.
    always_comb begin
        enter_resp = 1'b0;
        if (in_idle && access && (WAIT_CYCLES == 0)) begin
            enter_resp = 1'b1;
        end else if ((state == S_WAIT) && psel_i && (wait_cnt == 4'd1)) begin
            enter_resp = 1'b1;
        end
    end

    // Writes land and counters move on the edge that ends S_RESP.
    assign commit_ok   = (state == S_RESP) && !dec_err;
    assign bank_wr_en  = commit_ok && cap_write;
    assign bank_wr_inc = commit_ok && cap_write;
    assign bank_rd_inc = commit_ok && !cap_write;

    // FSM, wait counter and capture registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        cap_addr  <= paddr_i;
                        cap_write <= pwrite_i;
                        cap_wdata <= pwdata_i;
                        wait_cnt  <= WAIT_LD;
                        state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!psel_i) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd1) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered response outputs, loaded on entry to S_RESP and zero otherwise.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= '0;
        end else begin
            pready_o  <= enter_resp;
            pslverr_o <= enter_resp && dec_err;
            prdata_o  <= (enter_resp && !dec_err && !dec_write) ? bank_rd_data : '0;
        end
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .pclk     (pclk),
        .preset_n (preset_n),
        .wr_en    (bank_wr_en),
        .idx      (dec_idx),
        .wr_data  (cap_wdata),
        .rd_inc   (bank_rd_inc),
        .wr_inc   (bank_wr_inc),
        .rd_data  (bank_rd_data)
    );

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

APB completer that answers the `apb_add_master` read-increment-write traffic. It holds a small bank of 32-bit data registers at a fixed base address, inserts a parameterised number of wait states, and flags illegal accesses with `pslverr_o`. A read-only status word reports successful read and write counts. It connects directly to the master's `psel_o`/`penable_o`/`paddr_o`/`pwrite_o`/`pwdata_o` outputs and returns `prdata_o`/`pready_o`.

## Interface
- `BASE_ADDR`, 32'hA000, byte address of data register 0.
- `NUM_REGS`, 8, number of RW data registers (1..64); reg n lives at `BASE_ADDR + 4n`.
- `WAIT_CYCLES`, 2, wait states inserted before `pready_o` (0..15).
- `pclk` in 1: clock. Reset `preset_n`, asynchronous, active-low; clock `pclk`.
- `preset_n` in 1: asynchronous active-low reset.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable (access phase).
- `paddr_i` in 32: byte address, valid only while `penable_i`=1.
- `pwrite_i` in 1: 1 = write, 0 = read.
- `pwdata_i` in 32: write data, valid only while `penable_i`=1.
- `prdata_o` out 32: read data, valid only while `pready_o`=1, otherwise 0.
- `pready_o` out 1: transfer complete, registered.
- `pslverr_o` out 1: error response, valid only while `pready_o`=1, otherwise 0.

## Operation
- Status word lives at `BASE_ADDR + 4*NUM_REGS`. It is read-only: `{rd_cnt[15:0], wr_cnt[15:0]}`.
- FSM states: `S_IDLE`, `S_WAIT`, `S_RESP`.
- `S_IDLE`
  - On `psel_i & penable_i`, capture `paddr_i`, `pwrite_i` and `pwdata_i`.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to `S_WAIT`, or to `S_RESP` if `WAIT_CYCLES`=0.
  - `psel_i` alone (setup phase) is ignored, because the master presents `paddr`=0 during setup.
- `S_WAIT`
  - Decrement the counter each cycle; go to `S_RESP` when the counter reaches 1.
  - If `psel_i` drops, abort: go to `S_IDLE` with no commit and no count.
- `S_RESP`
  - `pready_o`=1 for exactly one cycle, then go to `S_IDLE` unconditionally.
- Decode is done on the captured address. Error when:
  - the address is outside `[BASE_ADDR, BASE_ADDR + 4*NUM_REGS]`, or
  - `addr[1:0]`≠0, or
  - the access is a write to the status word.
- Read OK: `prdata_o` = register value, `pslverr_o`=0, and `rd_cnt` increments.
- Write OK: the register takes the captured `pwdata` on the rising edge that ends `S_RESP`, and `wr_cnt` increments. A read issued afterwards returns the new value.
- Error: `prdata_o`=0, `pslverr_o`=1, no register update, no count.
- Counters saturate at 16'hFFFF; they never wrap.

## Timing
- Reset values: all outputs 0, all registers 0, counters 0, FSM in `S_IDLE`.
- Access phase length is `WAIT_CYCLES`+2 cycles. Cycle A1 captures and drives `pready_o`=0, then `WAIT_CYCLES` cycles follow, then one `S_RESP` cycle.
- With the master (setup + access), a transfer occupies `WAIT_CYCLES`+3 cycles.
- `prdata_o` and `pslverr_o` are registered and load on entry to `S_RESP`. They return to 0 the cycle after.
- Back-to-back transfers: the cycle after `S_RESP`, the FSM is in `S_IDLE` and accepts a new access-phase cycle.
- Re-capture is prevented because `S_RESP` → `S_IDLE` is unconditional. The master drops `penable` the cycle after `pready`.
- Reset mid-transfer: the FSM returns to `S_IDLE` immediately and any pending write is discarded.
- `pready_o` never asserts without a preceding captured access.

## Structure
- Package `apb_pkg` holds:
  - `typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} apb_slv_state_t`
  - `APB_ADDR_W`=32 and `APB_DATA_W`=32
  - `APB_WORD_BYTES`=4
- One sub-module, `apb_reg_bank`:
  - holds `NUM_REGS` data registers and the two saturating counters;
  - inputs: write enable, index, write data, `rd_inc`, `wr_inc`;
  - output: combinational read data for an index, with the status word at index `NUM_REGS`.
- The top level holds the FSM, the wait counter, the capture registers, address decode and error generation.

## Test plan
- **Reset then read:** reset, then read 0xA000 → `prdata_o`=0, `pslverr_o`=0, `pready_o` high exactly 4 cycles after `psel_i` rises (`WAIT_CYCLES`=2), status reads 32'h0001_0000.
- **Pair with `apb_add_master`:** drive `add_i`=01 then 11, three times → reg0 = 3, status = 32'h0003_0003.
- **Write/read regs:** write 0xDEADBEEF to 0xA01C, read it back → 0xDEADBEEF. Read 0xA020 (status) → `{16'd1,16'd1}`.
- **Error responses:**
  - write to 0xA020 → `pslverr_o`=1, status unchanged;
  - read 0xA024 → `pslverr_o`=1, `prdata_o`=0;
  - read 0xA002 → `pslverr_o`=1.
- **Abort and reset:** drop `psel_i` during `S_WAIT` on a write of 0x55 to 0xA004 → reg1 stays 0, `wr_cnt` unchanged. Assert `preset_n`=0 mid-wait → `pready_o`=0 immediately, all registers 0.
- **Edge configs:** with `WAIT_CYCLES`=0, `pready_o` arrives on the 2nd access cycle. Force `wr_cnt`=16'hFFFE and do 3 writes → `wr_cnt`=16'hFFFF.
